mac_reg_arbiter: RTL and testbench
==================================

Name: mac_reg_arbiter

Overview:
- Shares the single Ethernet MAC register port between two requesters: requester 0 is the eth0 configuration sequencer, requester 1 is the statistics/status poller.
- Performs round-robin arbitration and issues one read or write per grant under the MAC busy (wait-request) handshake.
- Enforces a busy timeout and returns per-requester completion, read data and an error flag.
- Sits between the requesters and the MAC register interface, in the clk_hifreq domain.

Parameters:
ADDR_W, 8, register address width
DATA_W, 32, register data width
TIMEOUT_CYCLES, 1024, maximum busy-stall cycles before a transfer is abandoned (must be >= 2)

Ports:
clk_hifreq  in  1  system clock
rst  in  1  asynchronous, active-low reset
req0, req1  in  1 each  transfer request; held high with command fields stable until the matching done pulse
we0, we1  in  1 each  1 = write, 0 = read
addr0, addr1  in  ADDR_W each  register address
wdata0, wdata1  in  DATA_W each  write data
done0, done1  out  1 each  one-cycle completion pulse
err0, err1  out  1 each  timeout flag, valid with done
rdata0, rdata1  out  DATA_W each  read result, held until the next completion for that requester
reg_addr  out  ADDR_W  MAC register address
data_out  out  DATA_W  MAC write data
wren  out  1  MAC write strobe
rden  out  1  MAC read strobe
data_in  in  DATA_W  MAC read data, valid in the cycle busy=0 while rden=1
busy  in  1  MAC wait-request; a command is accepted on a cycle with (wren|rden)=1 and busy=0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; every output = 0; internal last_grant=1, so requester 0 wins the first tie; timeout counter = 0.
- FSM states: IDLE, ISSUE, COMPLETE.
- IDLE:
  - No request: remain in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester not equal to last_grant.
  - On a grant: latch the requester's addr, wdata and we into registers; set last_grant = granted id; go to ISSUE.
- ISSUE:
  - Drive reg_addr and data_out from the latched values; wren = latched we, rden = ~latched we.
  - Hold all four signals stable while busy=1.
  - busy=0: the command is accepted. For a read, capture data_in into the granted requester's rdata. Go to COMPLETE.
  - busy=1: increment the timeout counter. When the counter reaches TIMEOUT_CYCLES-1 with busy still 1, drop wren/rden, set the abandon flag, and go to COMPLETE. rdata is not updated on timeout.
- COMPLETE:
  - wren = rden = 0.
  - Pulse the granted requester's done for 1 cycle; err = abandon flag.
  - Clear the counter and the flag; go to IDLE.
- Latency: a request seen in IDLE at cycle N gives the strobe at N+1. With busy=0 at N+1, done pulses at N+2. Minimum 3-cycle turnaround per transfer, so two back-to-back transfers take 6 cycles.
- Outside ISSUE, reg_addr and data_out retain their last value; only the strobes are cleared.
- A requester that drops req before its done pulse does not cancel the in-flight transfer; done is still pulsed.
- A request that stays high after its done is treated as a new request, re-arbitrated in the next IDLE cycle.
- err0/err1 are 0 whenever the corresponding done is 0.
- Asserting rst mid-ISSUE aborts the transfer immediately: no done pulse, strobes go to 0 asynchronously.

Test Plan:
- Single write: req0=1, we0=1, addr0=8'h02, wdata0=32'h0000_0003, busy=0 -> wren=1 with reg_addr=8'h02 and data_out=32'h3 for exactly 1 cycle; done0 pulses 2 cycles after the request is sampled; err0=0.
- Read with stall: req1=1, we1=0, addr1=8'h03; busy=1 for 5 cycles, then busy=0 with data_in=32'h17231C00 -> rden held for 6 cycles with reg_addr stable; rdata1=32'h17231C00; done1=1, err1=0.
- Contention fairness: req0 and req1 both held high continuously with busy=0 -> grant order 0,1,0,1; done0 and done1 alternate, 3 cycles apart.
- Timeout: TIMEOUT_CYCLES=16, req0 write with busy stuck at 1 -> wren high for 16 cycles then 0; done0=1 with err0=1; rdata0 unchanged. A following req1 is still serviced normally.
- Reset mid-transfer: rst=0 during a busy-stalled ISSUE -> wren/rden/done go to 0 without waiting for a clock edge. After release, a req1 in the same cycle as a req0 is granted to req0 first.

Source files
------------

// File: rtl/mac_reg_arbiter.sv
// Round-robin arbiter sharing the MAC register port between the eth0 config
// sequencer (req0) and the stats poller (req1), with a busy-stall timeout.
module mac_reg_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_hifreq,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              wren,
  output logic              rden,
  input  logic [DATA_W-1:0] data_in,
  input  logic              busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} state_e;

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                abandon_q, abandon_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                sel;

  always_ff @(posedge clk_hifreq or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      abandon_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      abandon_q <= abandon_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    abandon_d = abandon_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    // On a tie the requester that did not win last time is chosen
    sel       = (req0 && req1) ? ~last_q : req1;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = sel;
          last_d  = sel;
          we_d    = sel ? we1 : we0;
          addr_d  = sel ? addr1 : addr0;
          wdata_d = sel ? wdata1 : wdata0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!busy) begin
          if (!we_q) begin
            if (gnt_q) rdata1_d = data_in;
            else       rdata0_d = data_in;
          end
          state_d = COMPLETE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          abandon_d = 1'b1;
          state_d   = COMPLETE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COMPLETE: begin
        cnt_d     = '0;
        abandon_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wren     = (state_q == ISSUE) &&  we_q;
    rden     = (state_q == ISSUE) && !we_q;
    done0    = (state_q == COMPLETE) && !gnt_q;
    done1    = (state_q == COMPLETE) &&  gnt_q;
    err0     = done0 && abandon_q;
    err1     = done1 && abandon_q;
    reg_addr = addr_q;
    data_out = wdata_q;
    rdata0   = rdata0_q;
    rdata1   = rdata1_q;
  end

endmodule

// File: tb/tb_mac_reg_arbiter.sv
// Directed bench for mac_reg_arbiter: write, stalled read, fairness,
// timeout and asynchronous reset mid-transfer.
module tb_mac_reg_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          done0, done1, err0, err1, wren, rden;
  logic [DW-1:0] rdata0, rdata1, data_out;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] data_in = '0;
  logic          busy = 1'b0;

  int checks = 0;
  int errors = 0;

  mac_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_hifreq(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .reg_addr(reg_addr), .data_out(data_out), .wren(wren), .rden(rden),
    .data_in(data_in), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if ({wren, rden, done0, done1, err0, err1} !== 6'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b exp 000000", {wren, rden, done0, done1, err0, err1}); end
    checks++; if (rdata0 !== '0 || rdata1 !== '0) begin errors++;
      $display("FAIL reset_rdata: got %h/%h exp 0/0", rdata0, rdata1); end
    checks++; if (reg_addr !== '0 || data_out !== '0) begin errors++;
      $display("FAIL reset_bus: got %h/%h exp 0/0", reg_addr, data_out); end
    tick;
    rst = 1'b1;
  endtask

  task automatic test_single_write;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h02; wdata0 = 32'h0000_0003; busy = 1'b0;
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL wr_idle: got %b exp 0", wren); end
    tick;
    checks++; if (wren !== 1'b1 || rden !== 1'b0) begin errors++;
      $display("FAIL wr_strobe: got %b%b exp 10", wren, rden); end
    checks++; if (reg_addr !== 8'h02 || data_out !== 32'h3) begin errors++;
      $display("FAIL wr_bus: got %h/%h exp 02/00000003", reg_addr, data_out); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL wr_early_done: got %b exp 0", done0); end
    tick;
    checks++; if (wren !== 1'b0 || done0 !== 1'b1 || err0 !== 1'b0 || done1 !== 1'b0) begin errors++;
      $display("FAIL wr_done: got wren=%b done0=%b err0=%b done1=%b exp 0 1 0 0", wren, done0, err0, done1); end
    req0 = 1'b0;
    tick;
    checks++; if (done0 !== 1'b0 || wren !== 1'b0 || reg_addr !== 8'h02) begin errors++;
      $display("FAIL wr_after: got done0=%b wren=%b addr=%h exp 0 0 02", done0, wren, reg_addr); end
  endtask

  task automatic test_read_stall;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h03; busy = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      if (k == 6) begin busy = 1'b0; data_in = 32'h1723_1C00; end
      checks++; if (rden !== 1'b1 || wren !== 1'b0 || reg_addr !== 8'h03 || done1 !== 1'b0 || err1 !== 1'b0) begin
        errors++; $display("FAIL rd_stall[%0d]: got rden=%b wren=%b addr=%h done1=%b err1=%b exp 1 0 03 0 0",
                           k, rden, wren, reg_addr, done1, err1); end
    end
    tick;
    data_in = 32'hDEAD_BEEF;
    checks++; if (done1 !== 1'b1 || err1 !== 1'b0 || rden !== 1'b0) begin errors++;
      $display("FAIL rd_done: got done1=%b err1=%b rden=%b exp 1 0 0", done1, err1, rden); end
    checks++; if (rdata1 !== 32'h1723_1C00 || rdata0 !== 32'h0) begin errors++;
      $display("FAIL rd_data: got %h/%h exp 00000000/17231c00", rdata0, rdata1); end
    req1 = 1'b0;
    tick;
    checks++; if (done1 !== 1'b0 || rdata1 !== 32'h1723_1C00) begin errors++;
      $display("FAIL rd_hold: got done1=%b rdata1=%h exp 0 17231c00", done1, rdata1); end
  endtask

  task automatic test_contention;
    logic ed0, ed1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 32'hA0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h11; wdata1 = 32'hB1;
    busy = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick;
      ed0 = (k == 2 || k == 8);
      ed1 = (k == 5 || k == 11);
      checks++; if (done0 !== ed0 || done1 !== ed1) begin errors++;
        $display("FAIL fair_done[%0d]: got %b%b exp %b%b", k, done0, done1, ed0, ed1); end
      if (k == 1 || k == 7) begin
        checks++; if (wren !== 1'b1 || reg_addr !== 8'h10 || data_out !== 32'hA0) begin errors++;
          $display("FAIL fair_g0[%0d]: got wren=%b addr=%h data=%h exp 1 10 a0", k, wren, reg_addr, data_out); end
      end
      if (k == 4 || k == 10) begin
        checks++; if (wren !== 1'b1 || reg_addr !== 8'h11 || data_out !== 32'hB1) begin errors++;
          $display("FAIL fair_g1[%0d]: got wren=%b addr=%h data=%h exp 1 11 b1", k, wren, reg_addr, data_out); end
      end
      if (k == 11) begin req0 = 1'b0; req1 = 1'b0; end
    end
    tick;
    checks++; if (wren !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) begin errors++;
      $display("FAIL fair_idle: got %b%b%b exp 000", wren, done0, done1); end
  endtask

  task automatic test_timeout;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 32'h55; busy = 1'b1;
    for (int k = 1; k <= TO; k++) begin
      tick;
      checks++; if (wren !== 1'b1 || done0 !== 1'b0 || err0 !== 1'b0) begin errors++;
        $display("FAIL to_wr_stall[%0d]: got wren=%b done0=%b err0=%b exp 1 0 0", k, wren, done0, err0); end
    end
    tick;
    checks++; if (wren !== 1'b0 || done0 !== 1'b1 || err0 !== 1'b1 || err1 !== 1'b0) begin errors++;
      $display("FAIL to_wr_done: got wren=%b done0=%b err0=%b err1=%b exp 0 1 1 0", wren, done0, err0, err1); end
    req0 = 1'b0;
    tick;
    checks++; if (done0 !== 1'b0 || err0 !== 1'b0) begin errors++;
      $display("FAIL to_wr_clear: got %b%b exp 00", done0, err0); end
    // read timeout: data_in must not reach rdata0
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h21; data_in = 32'hDEAD_BEEF;
    for (int k = 1; k <= TO; k++) begin
      tick;
      checks++; if (rden !== 1'b1 || done0 !== 1'b0) begin errors++;
        $display("FAIL to_rd_stall[%0d]: got rden=%b done0=%b exp 1 0", k, rden, done0); end
    end
    tick;
    checks++; if (rden !== 1'b0 || done0 !== 1'b1 || err0 !== 1'b1 || rdata0 !== 32'h0) begin errors++;
      $display("FAIL to_rd_done: got rden=%b done0=%b err0=%b rdata0=%h exp 0 1 1 00000000", rden, done0, err0, rdata0); end
    req0 = 1'b0; busy = 1'b0;
    tick;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h30; wdata1 = 32'h77;
    tick;
    checks++; if (wren !== 1'b1 || reg_addr !== 8'h30 || data_out !== 32'h77) begin errors++;
      $display("FAIL to_next_issue: got wren=%b addr=%h data=%h exp 1 30 77", wren, reg_addr, data_out); end
    tick;
    checks++; if (done1 !== 1'b1 || err1 !== 1'b0 || done0 !== 1'b0) begin errors++;
      $display("FAIL to_next_done: got done1=%b err1=%b done0=%b exp 1 0 0", done1, err1, done0); end
    req1 = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 32'h99; busy = 1'b1;
    tick;
    tick;
    checks++; if (wren !== 1'b1) begin errors++; $display("FAIL rst_pre: got %b exp 1", wren); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if ({wren, rden, done0, done1} !== 4'b0) begin errors++;
      $display("FAIL rst_async: got %b exp 0000", {wren, rden, done0, done1}); end
    checks++; if (reg_addr !== '0 || rdata1 !== '0) begin errors++;
      $display("FAIL rst_regs: got %h/%h exp 00/00000000", reg_addr, rdata1); end
    tick;
    checks++; if ({wren, rden, done0, done1} !== 4'b0) begin errors++;
      $display("FAIL rst_held: got %b exp 0000", {wren, rden, done0, done1}); end
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h50; wdata0 = 32'h5;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h51; wdata1 = 32'h6;
    busy = 1'b0;
    rst = 1'b1;
    tick;
    checks++; if (wren !== 1'b1 || reg_addr !== 8'h50 || data_out !== 32'h5) begin errors++;
      $display("FAIL rst_first_gnt: got wren=%b addr=%h data=%h exp 1 50 5", wren, reg_addr, data_out); end
    tick;
    checks++; if (done0 !== 1'b1 || done1 !== 1'b0) begin errors++;
      $display("FAIL rst_first_done: got %b%b exp 10", done0, done1); end
    req0 = 1'b0;
    tick;
    tick;
    checks++; if (wren !== 1'b1 || reg_addr !== 8'h51) begin errors++;
      $display("FAIL rst_second_gnt: got wren=%b addr=%h exp 1 51", wren, reg_addr); end
    tick;
    checks++; if (done1 !== 1'b1 || done0 !== 1'b0) begin errors++;
      $display("FAIL rst_second_done: got %b%b exp 01", done0, done1); end
    req1 = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_read_stall;
    test_contention;
    test_timeout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
